pipe_stage_reg: RTL and testbench

Parametrised, elastic successor to the fixed EX/MEM stage register. It carries an opaque payload plus hazard-visible fields between two pipeline stages using a valid/ready handshake. It adds a legacy stall, a flush, and an optional 2-entry skid buffer that registers in_ready. Saturating stall and flush-kill counters support trace and performance monitoring. The same block is instantiated for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_stage_reg_sat_counter.sv | 28 ++
 rtl/pipe_stage_reg.sv | 146 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline stage registers: state encodings and
// the payload width carried across each pipeline boundary.
package pipe_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKIDF = 2'd2;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 160;
  localparam int EX_MEM_W = 128;
  localparam int MEM_WB_W = 96;
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter; adds 1 on inc and 2 on inc2, and holds at all-ones.
// The count is registered, so it reflects events one cycle later; it has no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         inc2,
  output logic [W-1:0] cnt
);
  localparam logic [W:0] MAX = {1'b0, {W{1'b1}}};

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {{(W-1){1'b0}}, inc2, inc};
    cnt_d = (sum > MAX) ? {W{1'b1}} : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready stage register with stall, flush and an optional 2-entry skid buffer.
// Latency is 1 cycle; with SKID=1 in_ready is registered, otherwise it follows out_ready combinationally.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int WR_W   = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WR_W-1:0]   in_wr,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [WR_W-1:0]   out_wr,
  output logic              out_we,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  kill_cnt
);
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [WR_W-1:0]   main_wr_q, main_wr_d, skid_wr_q, skid_wr_d;
  logic              main_we_q, main_we_d, skid_we_q, skid_we_d;
  logic              rdy_q, rdy_d;
  logic              fire_in, fire_out;
  logic              kill_one, kill_two;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_wr_d   = main_wr_q;
    main_we_d   = main_we_q;
    skid_data_d = skid_data_q;
    skid_wr_d   = skid_wr_q;
    skid_we_d   = skid_we_q;

    out_valid = (state_q != ST_EMPTY);
    fire_out  = out_valid & out_ready & ~stall;
    in_ready  = (SKID != 0) ? (~stall & rdy_q) : (~stall & (~out_valid | out_ready));
    fire_in   = in_valid & in_ready;

    if (flush) begin
      state_d = ST_EMPTY;
    end else if (!stall) begin
      if (SKID != 0) begin
        case (state_q)
          ST_EMPTY: begin
            if (fire_in) begin
              state_d     = ST_FULL;
              main_data_d = in_data;
              main_wr_d   = in_wr;
              main_we_d   = in_we;
            end
          end
          ST_FULL: begin
            if (fire_in && !fire_out) begin
              state_d     = ST_SKIDF;
              skid_data_d = in_data;
              skid_wr_d   = in_wr;
              skid_we_d   = in_we;
            end else if (fire_in) begin
              main_data_d = in_data;
              main_wr_d   = in_wr;
              main_we_d   = in_we;
            end else if (fire_out) begin
              state_d = ST_EMPTY;
            end
          end
          ST_SKIDF: begin
            if (fire_out) begin
              state_d     = ST_FULL;
              main_data_d = skid_data_q;
              main_wr_d   = skid_wr_q;
              main_we_d   = skid_we_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end else begin
        if (fire_in) begin
          state_d     = ST_FULL;
          main_data_d = in_data;
          main_wr_d   = in_wr;
          main_we_d   = in_we;
        end else if (fire_out) begin
          state_d = ST_EMPTY;
        end
      end
    end

    // Ready is precomputed from the next state so in_ready never depends on out_ready.
    rdy_d    = (state_d != ST_SKIDF);
    kill_one = flush & (state_q == ST_FULL);
    kill_two = flush & (state_q == ST_SKIDF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_wr_q   <= '0;
      main_we_q   <= 1'b0;
      skid_data_q <= '0;
      skid_wr_q   <= '0;
      skid_we_q   <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_wr_q   <= main_wr_d;
      main_we_q   <= main_we_d;
      skid_data_q <= skid_data_d;
      skid_wr_q   <= skid_wr_d;
      skid_we_q   <= skid_we_d;
      rdy_q       <= rdy_d;
    end
  end

  assign out_data = main_data_q;
  assign out_wr   = main_wr_q;
  assign out_we   = main_we_q & out_valid;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall & out_valid),
    .inc2 (1'b0),
    .cnt  (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_kill_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (kill_one),
    .inc2 (kill_two),
    .cnt  (kill_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid instance (SKID=1) and non-skid instance (SKID=0, CNT_W=2).
module tb_pipe_stage_reg;
  logic         clk = 1'b0;
  int           checks = 0;
  int           errors = 0;

  logic         a_rst_n, a_stall, a_flush, a_in_valid, a_in_ready, a_in_we;
  logic         a_out_valid, a_out_ready, a_out_we;
  logic [127:0] a_in_data, a_out_data;
  logic [4:0]   a_in_wr, a_out_wr;
  logic [15:0]  a_stall_cnt, a_kill_cnt;

  logic         b_rst_n, b_stall, b_flush, b_in_valid, b_in_ready, b_in_we;
  logic         b_out_valid, b_out_ready, b_out_we;
  logic [127:0] b_in_data, b_out_data;
  logic [4:0]   b_in_wr, b_out_wr;
  logic [1:0]   b_stall_cnt, b_kill_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(128), .WR_W(5), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst_n(a_rst_n), .stall(a_stall), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_wr(a_in_wr), .in_we(a_in_we), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_wr(a_out_wr),
    .out_we(a_out_we), .stall_cnt(a_stall_cnt), .kill_cnt(a_kill_cnt)
  );

  pipe_stage_reg #(.DATA_W(128), .WR_W(5), .SKID(0), .CNT_W(2)) u_flat (
    .clk(clk), .rst_n(b_rst_n), .stall(b_stall), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_wr(b_in_wr), .in_we(b_in_we), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_wr(b_out_wr),
    .out_we(b_out_we), .stall_cnt(b_stall_cnt), .kill_cnt(b_kill_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    tick(); tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0h expected 0", a_out_valid); end
    checks++; if (a_out_we !== 1'b0) begin errors++; $display("FAIL rst_out_we: got %0h expected 0", a_out_we); end
    checks++; if (a_out_data !== 128'h0) begin errors++; $display("FAIL rst_out_data: got %0h expected 0", a_out_data); end
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", a_stall_cnt); end
    checks++; if (a_kill_cnt !== 16'd0) begin errors++; $display("FAIL rst_kill_cnt: got %0d expected 0", a_kill_cnt); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_out_valid: got %0h expected 0", b_out_valid); end
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0h expected 1", a_in_ready); end
  endtask

  task automatic test_single();
    a_in_valid = 1'b1; a_in_data = 128'hA5; a_in_wr = 5'd3; a_in_we = 1'b1; a_out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0h expected 1", a_out_valid); end
    checks++; if (a_out_data !== 128'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", a_out_data); end
    checks++; if (a_out_wr !== 5'd3) begin errors++; $display("FAIL single_wr: got %0d expected 3", a_out_wr); end
    checks++; if (a_out_we !== 1'b1) begin errors++; $display("FAIL single_we: got %0h expected 1", a_out_we); end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %0h expected 0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1'b1; a_in_data = 128'h10 + 128'(i); a_in_wr = 5'(i);
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %0h expected 1", i, a_in_ready); end
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 128'h10 + 128'(i))
        begin errors++; $display("FAIL b2b_beat[%0d]: got valid %0h data %0h expected valid 1 data %0h", i, a_out_valid, a_out_data, 128'h10 + 128'(i)); end
    end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %0h expected 0", a_out_valid); end
  endtask

  task automatic test_skid();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 128'h1; a_in_wr = 5'd1;
    tick();
    a_in_data = 128'h2; a_in_wr = 5'd2;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready2: got %0h expected 1", a_in_ready); end
    tick();
    a_in_data = 128'h3; a_in_wr = 5'd3;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_full: got %0h expected 0", a_in_ready); end
    tick();
    checks++; if (a_out_data !== 128'h1 || a_in_ready !== 1'b0)
      begin errors++; $display("FAIL skid_hold: got data %0h ready %0h expected data 1 ready 0", a_out_data, a_in_ready); end
    a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_no_comb: got %0h expected 0", a_in_ready); end
    tick();
    checks++; if (a_out_data !== 128'h2 || a_out_valid !== 1'b1)
      begin errors++; $display("FAIL skid_second: got data %0h valid %0h expected 2 1", a_out_data, a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %0h expected 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_data !== 128'h3 || a_out_valid !== 1'b1)
      begin errors++; $display("FAIL skid_third: got data %0h valid %0h expected 3 1", a_out_data, a_out_valid); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty: got %0h expected 0", a_out_valid); end
  endtask

  task automatic test_stall();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 128'h7;
    tick();
    a_in_valid = 1'b0; a_stall = 1'b1; a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %0h expected 0", a_in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 128'h7)
        begin errors++; $display("FAIL stall_hold[%0d]: got valid %0h data %0h expected 1 7", i, a_out_valid, a_out_data); end
    end
    checks++; if (a_stall_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt: got %0d expected 4", a_stall_cnt); end
    a_stall = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_stall_cnt !== 16'd4)
      begin errors++; $display("FAIL stall_release: got valid %0h cnt %0d expected 0 4", a_out_valid, a_stall_cnt); end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_we = 1'b1; a_in_data = 128'h1;
    tick();
    a_in_data = 128'h2;
    tick();
    a_in_data = 128'h55; a_flush = 1'b1; a_stall = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_out_we !== 1'b0)
      begin errors++; $display("FAIL flush_out: got valid %0h we %0h expected 0 0", a_out_valid, a_out_we); end
    checks++; if (a_kill_cnt !== 16'd2) begin errors++; $display("FAIL flush_kill_cnt: got %0d expected 2", a_kill_cnt); end
    checks++; if (a_stall_cnt !== 16'd5) begin errors++; $display("FAIL flush_stall_cnt: got %0d expected 5", a_stall_cnt); end
    a_flush = 1'b0; a_stall = 1'b0; a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_after: got valid %0h ready %0h expected 0 1", a_out_valid, a_in_ready); end
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 128'h1;
    tick();
    a_in_data = 128'h2;
    tick();
    a_rst_n = 1'b0; a_flush = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_kill_cnt !== 16'd0 || a_stall_cnt !== 16'd0)
      begin errors++; $display("FAIL rstmid: got valid %0h kill %0d stall %0d expected 0 0 0", a_out_valid, a_kill_cnt, a_stall_cnt); end
    a_rst_n = 1'b1; a_flush = 1'b0; a_in_data = 128'h9; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 128'h9)
      begin errors++; $display("FAIL rstmid_first: got valid %0h data %0h expected 1 9", a_out_valid, a_out_data); end
    tick();
  endtask

  task automatic test_no_skid();
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 128'h21; b_in_we = 1'b1;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL ns_ready_empty: got %0h expected 1", b_in_ready); end
    tick();
    b_in_data = 128'h22;
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL ns_ready_full: got %0h expected 0", b_in_ready); end
    b_stall = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (b_stall_cnt !== 2'd3) begin errors++; $display("FAIL ns_stall_sat: got %0d expected 3", b_stall_cnt); end
    checks++; if (b_out_data !== 128'h21) begin errors++; $display("FAIL ns_stall_hold: got %0h expected 21", b_out_data); end
    b_stall = 1'b0;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL ns_ready_comb: got %0h expected 1", b_in_ready); end
    tick();
    b_in_valid = 1'b0;
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 128'h22)
      begin errors++; $display("FAIL ns_swap: got valid %0h data %0h expected 1 22", b_out_valid, b_out_data); end
    checks++; if (b_stall_cnt !== 2'd3) begin errors++; $display("FAIL ns_cnt_hold: got %0d expected 3", b_stall_cnt); end
    tick();
    checks++; if (b_out_valid !== 1'b0 || b_out_we !== 1'b0)
      begin errors++; $display("FAIL ns_drain: got valid %0h we %0h expected 0 0", b_out_valid, b_out_we); end
  endtask

  initial begin
    a_rst_n = 1'b0; a_stall = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0;
    a_in_data = '0; a_in_wr = '0; a_in_we = 1'b0; a_out_ready = 1'b0;
    b_rst_n = 1'b0; b_stall = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0;
    b_in_data = '0; b_in_wr = '0; b_in_we = 1'b0; b_out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_skid();
    test_stall();
    test_flush();
    test_reset_mid();
    test_no_skid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
